// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, round constants, IV, state
// encoding and the FIPS 180-4 logical functions used by the compressor.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Working variables packed so that [7] is a and [0] is h, which makes
  // the packed value line up directly with {a,b,c,d,e,f,g,h}.
  typedef logic [7:0][WORD_W-1:0] hash_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hash_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Word-wise modulo-2^32 sum of two hash states (digest feed-forward).
  function automatic hash_t add_hash(input hash_t x, input hash_t y);
    hash_t r;
    for (int i = 0; i < 8; i++) r[i] = x[i] + y[i];
    return r;
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: a 16-word sliding window holding W[t..t+15],
// loaded from the block and advanced UNROLL words per step.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          advance,
  input  logic [511:0]                  block_in,
  output logic [UNROLL-1:0][WORD_W-1:0] w_out
);

  word_t win      [16];
  word_t next_win [16];

  // Extend the window by UNROLL new words, each able to use the ones before it.
  always_comb begin : expand
    word_t ext [16+UNROLL];
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int i = 0; i < UNROLL; i++) begin
      ext[16+i] = small_sigma1(ext[14+i]) + ext[9+i] + small_sigma0(ext[1+i]) + ext[i];
    end
    for (int i = 0; i < 16; i++) next_win[i] = ext[i+UNROLL];
  end

  // Window register: cleared on reset, filled from the block, then slid forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block_in[511-32*i -: 32];
    end else if (advance) begin
      for (int i = 0; i < 16; i++) win[i] <= next_win[i];
    end
  end

  for (genvar g = 0; g < UNROLL; g++) begin : g_wout
    assign w_out[g] = win[g];
  end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression core, UNROLL rounds per clock (1, 2 or 4).
// Optional macro SHA256_FEEDFORWARD_EN: output the block digest (h_in + a..h)
// instead of the raw final working variables.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] h_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] vars_out
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("sha256_compress: UNROLL must be 1, 2 or 4");
  end

  localparam logic [5:0] STEP   = 6'(UNROLL);
  localparam logic [5:0] LAST_T = 6'(64 - UNROLL);

  state_t                     state, state_next;
  logic [5:0]                 round_cnt;
  hash_t                      vars, vars_next;
  logic [UNROLL-1:0][WORD_W-1:0] w_cur;
  logic                       load, advance;

  sha256_msg_sched #(.UNROLL(UNROLL)) u_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .advance  (advance),
    .block_in (block_in),
    .w_out    (w_cur)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state plus load/advance strobes; start only matters in IDLE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        state_next = ST_RUN;
        load       = 1'b1;
      end
      ST_RUN: begin
        advance = 1'b1;
        if (round_cnt == LAST_T) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Round counter t, stepping by UNROLL and wrapping back to 0 after the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       round_cnt <= '0;
    else if (load)    round_cnt <= '0;
    else if (advance) round_cnt <= round_cnt + STEP;
  end

  // Chain of UNROLL rounds applied to the current working variables.
  always_comb begin : rounds
    hash_t      s;
    word_t      t1, t2;
    logic [5:0] idx;
    s   = vars;
    t1  = '0;
    t2  = '0;
    idx = '0;
    for (int i = 0; i < UNROLL; i++) begin
      idx = round_cnt + 6'(i);
      t1  = s[0] + big_sigma1(s[3]) + ch(s[3], s[2], s[1]) + K[idx] + w_cur[i];
      t2  = big_sigma0(s[7]) + maj(s[7], s[6], s[5]);
      s   = {t1 + t2, s[7], s[6], s[5], s[4] + t1, s[3], s[2], s[1]};
    end
    vars_next = s;
  end

  // Working variables a..h: seeded from h_in at load, updated every RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vars <= '0;
    else if (load)    vars <= h_in;
    else if (advance) vars <= vars_next;
  end

`ifdef SHA256_FEEDFORWARD_EN
  hash_t h_saved;

  // Captured chaining value for the digest feed-forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    h_saved <= '0;
    else if (load) h_saved <= h_in;
  end

  assign vars_out = add_hash(vars, h_saved);
`else
  assign vars_out = vars;
`endif

endmodule
